// File: rtl/store_align_unit.sv
// store_align_unit
//
// Store-side write formatter between the MEM-stage store path and the data
// memory bus. One store request is accepted per handshake and turned into one
// or two NB-aligned bus beats carrying byte enables and lane-shifted data.
// Misaligned stores either split into two beats (SPLIT_EN=1) or are rejected
// with a one-cycle err pulse (SPLIT_EN=0). A doubleword store on a 32-bit bus
// is always rejected.
//
// Parameters
//   DATA_W    bus data width, 32 or 64 (NB = DATA_W/8 bytes per beat)
//   ADDR_W    byte address width
//   SPLIT_EN  1: split boundary-crossing stores, 0: reject misaligned stores
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous active-low reset
//   req_valid  in   store request present
//   req_ready  out  request accepted this cycle when req_valid is high
//   req_addr   in   byte address
//   req_width  in   00 word, 01 half, 10 byte, 11 doubleword
//   req_wdata  in   right-justified store data
//   m_valid    out  bus beat valid
//   m_ready    in   bus accepts beat
//   m_addr     out  NB-aligned beat address
//   m_byteen   out  byte enables of the beat
//   m_wdata    out  lane-shifted data, disabled lanes are zero
//   m_last     out  final beat of the current request
//   err        out  one-cycle pulse, request rejected
//   err_addr   out  address of the most recent rejected request
//
// States
//   S_IDLE  | waiting for a request, req_ready high
//   S_BEAT0 | presenting the first (or only) beat
//   S_BEAT1 | presenting the second beat of a boundary-crossing store
//   S_ERR   | pulsing err for the rejected request

module store_align_unit #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int SPLIT_EN = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [1:0]            req_width,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W/8-1:0]   m_byteen,
    output logic [DATA_W-1:0]     m_wdata,
    output logic                  m_last,
    output logic                  err,
    output logic [ADDR_W-1:0]     err_addr
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BEAT0 = 2'd1,
        S_BEAT1 = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    // request decode
    logic [3:0]          size;
    logic [2:0]          align_lsb;
    logic [OFF_W-1:0]    off;
    logic [4:0]          end_pos;
    logic                misaligned;
    logic                invalid;
    logic                crossing;
    logic                req_err;
    logic [2*NB-1:0]     size_mask;
    logic [2*NB-1:0]     mask2;
    logic [2*DATA_W-1:0] data_ext;
    logic [2*DATA_W-1:0] data_lo;
    logic [2*DATA_W-1:0] data2;
    logic [ADDR_W-1:0]   base_addr;

    // beat registers
    logic [ADDR_W-1:0]   addr_q;
    logic [NB-1:0]       byteen_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [NB-1:0]       hi_byteen_q;
    logic [DATA_W-1:0]   hi_wdata_q;
    logic                cross_q;
    logic [ADDR_W-1:0]   err_addr_q;

    logic                accept;
    logic                advance;

    always_comb begin
        size      = 4'd4;
        align_lsb = 3'b011;
        unique case (req_width)
            2'b00: begin size = 4'd4; align_lsb = 3'b011; end
            2'b01: begin size = 4'd2; align_lsb = 3'b001; end
            2'b10: begin size = 4'd1; align_lsb = 3'b000; end
            2'b11: begin size = 4'd8; align_lsb = 3'b111; end
        endcase
    end

    assign off        = req_addr[OFF_W-1:0];
    assign end_pos    = 5'(off) + 5'(size);
    assign misaligned = (req_addr[2:0] & align_lsb) != 3'b000;
    assign invalid    = (req_width == 2'b11) && (DATA_W == 32);
    assign crossing   = end_pos > 5'(NB);
    assign req_err    = invalid || (misaligned && (SPLIT_EN == 0));
    assign base_addr  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    // Masks live in a 2*NB-byte window so the part that spills past the beat
    // boundary lands directly in the upper half, ready for beat 1.
    always_comb begin
        size_mask = '0;
        for (int i = 0; i < 2*NB; i++) begin
            size_mask[i] = (i < int'(size));
        end
    end

    assign data_ext = {{DATA_W{1'b0}}, req_wdata};

    always_comb begin
        data_lo = '0;
        for (int i = 0; i < 2*NB; i++) begin
            data_lo[8*i +: 8] = size_mask[i] ? data_ext[8*i +: 8] : 8'h00;
        end
    end

    assign mask2 = size_mask << off;
    assign data2 = data_lo << {off, 3'b000};

    // state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state and state-decoded outputs
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        m_valid   = 1'b0;
        m_last    = 1'b0;
        err       = 1'b0;
        accept    = 1'b0;
        advance   = 1'b0;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = req_err ? S_ERR : S_BEAT0;
                end
            end
            S_BEAT0: begin
                m_valid = 1'b1;
                m_last  = !cross_q;
                if (m_ready) begin
                    advance   = cross_q;
                    state_nxt = cross_q ? S_BEAT1 : S_IDLE;
                end
            end
            S_BEAT1: begin
                m_valid = 1'b1;
                m_last  = 1'b1;
                if (m_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            S_ERR: begin
                err       = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Beat data is captured at acceptance; the upper half is parked until
    // beat 0 completes so the bus outputs stay stable under backpressure.
    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q      <= '0;
            byteen_q    <= '0;
            wdata_q     <= '0;
            hi_byteen_q <= '0;
            hi_wdata_q  <= '0;
            cross_q     <= 1'b0;
            err_addr_q  <= '0;
        end else if (accept) begin
            if (req_err) begin
                err_addr_q <= req_addr;
            end else begin
                addr_q      <= base_addr;
                byteen_q    <= mask2[NB-1:0];
                wdata_q     <= data2[DATA_W-1:0];
                hi_byteen_q <= mask2[2*NB-1:NB];
                hi_wdata_q  <= data2[2*DATA_W-1:DATA_W];
                cross_q     <= crossing;
            end
        end else if (advance) begin
            addr_q   <= addr_q + ADDR_W'(NB);
            byteen_q <= hi_byteen_q;
            wdata_q  <= hi_wdata_q;
        end
    end

    assign m_addr   = addr_q;
    assign m_byteen = byteen_q;
    assign m_wdata  = wdata_q;
    assign err_addr = err_addr_q;

endmodule

// File: tb/tb_store_align_unit.sv
module tb_store_align_unit;

    logic clk;
    logic reset;

    // instance 0: 32-bit split, 1: 32-bit reject, 2: 64-bit split
    logic        rv [3];
    logic [31:0] ra [3];
    logic [1:0]  rw [3];
    logic [63:0] rd [3];
    logic        mr [3];
    logic        rr [3];
    logic        mv [3];
    logic [31:0] ma [3];
    logic [7:0]  mb [3];
    logic [63:0] md [3];
    logic        ml [3];
    logic        er [3];
    logic [31:0] ea [3];

    logic [3:0]  mb0, mb1;
    logic [7:0]  mb2;
    logic [31:0] md0, md1;
    logic [63:0] md2;

    assign mb[0] = {4'h0, mb0};
    assign mb[1] = {4'h0, mb1};
    assign mb[2] = mb2;
    assign md[0] = {32'h0, md0};
    assign md[1] = {32'h0, md1};
    assign md[2] = md2;

    store_align_unit #(.DATA_W(32), .ADDR_W(32), .SPLIT_EN(1)) u0 (
        .clk(clk), .reset(reset),
        .req_valid(rv[0]), .req_ready(rr[0]), .req_addr(ra[0]), .req_width(rw[0]),
        .req_wdata(rd[0][31:0]),
        .m_valid(mv[0]), .m_ready(mr[0]), .m_addr(ma[0]), .m_byteen(mb0),
        .m_wdata(md0), .m_last(ml[0]), .err(er[0]), .err_addr(ea[0])
    );

    store_align_unit #(.DATA_W(32), .ADDR_W(32), .SPLIT_EN(0)) u1 (
        .clk(clk), .reset(reset),
        .req_valid(rv[1]), .req_ready(rr[1]), .req_addr(ra[1]), .req_width(rw[1]),
        .req_wdata(rd[1][31:0]),
        .m_valid(mv[1]), .m_ready(mr[1]), .m_addr(ma[1]), .m_byteen(mb1),
        .m_wdata(md1), .m_last(ml[1]), .err(er[1]), .err_addr(ea[1])
    );

    store_align_unit #(.DATA_W(64), .ADDR_W(32), .SPLIT_EN(1)) u2 (
        .clk(clk), .reset(reset),
        .req_valid(rv[2]), .req_ready(rr[2]), .req_addr(ra[2]), .req_width(rw[2]),
        .req_wdata(rd[2]),
        .m_valid(mv[2]), .m_ready(mr[2]), .m_addr(ma[2]), .m_byteen(mb2),
        .m_wdata(md2), .m_last(ml[2]), .err(er[2]), .err_addr(ea[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: works byte by byte from absolute addresses.
    // ------------------------------------------------------------------
    typedef struct {
        int          k;
        bit          is_err;
        logic [31:0] addr;
        logic [7:0]  be;
        logic [63:0] d;
        bit          last;
    } item_t;

    item_t       q[$];
    item_t       hd;
    bit          due [3];
    logic [31:0] last_ea [3];
    bit          check_en = 0;
    bit          prev_low = 0;

    function automatic int bytes_of(int k);
        return (k == 2) ? 8 : 4;
    endfunction

    function automatic bit split_of(int k);
        return (k != 1);
    endfunction

    function automatic void model_push(int k, logic [31:0] a, logic [1:0] w, logic [63:0] d);
        int    s;
        int    nb;
        int    off;
        int    nbeats;
        int    rel;
        int    lane;
        item_t it;
        s   = (w == 2'b00) ? 4 : (w == 2'b01) ? 2 : (w == 2'b10) ? 1 : 8;
        nb  = bytes_of(k);
        off = int'(a % 32'(nb));
        it.k = k;
        it.be = 8'h00;
        it.d = 64'h0;
        it.last = 1'b0;
        if ((s == 8 && nb == 4) || ((a % 32'(s)) != 32'h0 && !split_of(k))) begin
            it.is_err = 1'b1;
            it.addr = a;
            q.push_back(it);
            last_ea[k] = a;
            return;
        end
        nbeats = (off + s > nb) ? 2 : 1;
        it.is_err = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            it.be = 8'h00;
            it.d = 64'h0;
            for (int i = 0; i < s; i++) begin
                rel = off + i;
                if (rel / nb == b) begin
                    lane = rel % nb;
                    it.be[lane] = 1'b1;
                    it.d[8*lane +: 8] = d[8*i +: 8];
                end
            end
            it.addr = a - 32'(off) + 32'(b * nb);
            it.last = (b == nbeats - 1);
            q.push_back(it);
        end
    endfunction

    // ------------------------------------------------------------------
    // Per-cycle comparison against the model, sampled on the falling edge.
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (check_en && reset) begin
                if (prev_low) begin
                    chk($sformatf("u%0d reset m_addr", k), 64'(ma[k]), 64'd0);
                    chk($sformatf("u%0d reset m_byteen", k), 64'(mb[k]), 64'd0);
                    chk($sformatf("u%0d reset m_wdata", k), md[k], 64'd0);
                    chk($sformatf("u%0d reset m_last", k), 64'(ml[k]), 64'd0);
                end
                chk($sformatf("u%0d err_addr", k), 64'(ea[k]), 64'(last_ea[k]));
                if (due[k]) begin
                    chk($sformatf("u%0d req_ready busy", k), 64'(rr[k]), 64'd0);
                    if (q.size() == 0) begin
                        chk($sformatf("u%0d model queue", k), 64'd0, 64'd1);
                        due[k] = 1'b0;
                    end else begin
                        hd = q[0];
                        if (hd.is_err) begin
                            chk($sformatf("u%0d err pulse", k), 64'(er[k]), 64'd1);
                            chk($sformatf("u%0d m_valid on err", k), 64'(mv[k]), 64'd0);
                            void'(q.pop_front());
                            due[k] = 1'b0;
                        end else begin
                            chk($sformatf("u%0d m_valid", k), 64'(mv[k]), 64'd1);
                            chk($sformatf("u%0d err in beat", k), 64'(er[k]), 64'd0);
                            chk($sformatf("u%0d m_addr", k), 64'(ma[k]), 64'(hd.addr));
                            chk($sformatf("u%0d m_byteen", k), 64'(mb[k]), 64'(hd.be));
                            chk($sformatf("u%0d m_wdata", k), md[k], hd.d);
                            chk($sformatf("u%0d m_last", k), 64'(ml[k]), 64'(hd.last));
                            if (mr[k]) begin
                                void'(q.pop_front());
                                due[k] = (q.size() != 0);
                            end
                        end
                    end
                end else begin
                    chk($sformatf("u%0d m_valid idle", k), 64'(mv[k]), 64'd0);
                    chk($sformatf("u%0d err idle", k), 64'(er[k]), 64'd0);
                    chk($sformatf("u%0d req_ready idle", k), 64'(rr[k]), 64'd1);
                    if (rv[k]) begin
                        model_push(k, ra[k], rw[k], rd[k]);
                        due[k] = 1'b1;
                    end
                end
            end
        end
        if (!reset) begin
            q.delete();
            for (int k = 0; k < 3; k++) begin
                due[k] = 1'b0;
                last_ea[k] = 32'h0;
            end
            check_en = 1'b1;
            prev_low = 1'b1;
        end else begin
            prev_low = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (called at posedge + 1)
    // ------------------------------------------------------------------
    task automatic send(input int k, input logic [31:0] a, input logic [1:0] w, input logic [63:0] d);
        bit got;
        got = 1'b0;
        rv[k] = 1'b1;
        ra[k] = a;
        rw[k] = w;
        rd[k] = d;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (rr[k] === 1'b1) got = 1'b1;
        end
        if (!got) chk($sformatf("u%0d accept timeout", k), 64'd0, 64'd1);
        @(posedge clk);
        #1;
        rv[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int i;
        i = 0;
        while (due[k] && i < 20) begin
            @(posedge clk);
            #1;
            i++;
        end
        if (due[k]) chk($sformatf("u%0d completion timeout", k), 64'd0, 64'd1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL global timeout: run did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

    initial begin
        logic [63:0] pat;
        for (int k = 0; k < 3; k++) begin
            rv[k] = 1'b0;
            ra[k] = 32'h0;
            rw[k] = 2'b00;
            rd[k] = 64'h0;
            mr[k] = 1'b1;
        end
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        step();

        // sb to 0x2002, 32-bit split
        send(0, 32'h2002, 2'b10, 64'h12345678);
        chk("t1 m_valid", 64'(mv[0]), 64'd1);
        chk("t1 m_addr", 64'(ma[0]), 64'h2000);
        chk("t1 m_byteen", 64'(mb[0]), 64'b0100);
        chk("t1 m_wdata", md[0], 64'h00780000);
        chk("t1 m_last", 64'(ml[0]), 64'd1);
        wait_idle(0);

        // sh to 0x1003 splits
        send(0, 32'h1003, 2'b01, 64'h0000ABCD);
        chk("t2 b0 m_addr", 64'(ma[0]), 64'h1000);
        chk("t2 b0 m_byteen", 64'(mb[0]), 64'b1000);
        chk("t2 b0 m_wdata", md[0], 64'hCD000000);
        chk("t2 b0 m_last", 64'(ml[0]), 64'd0);
        step();
        chk("t2 b1 m_addr", 64'(ma[0]), 64'h1004);
        chk("t2 b1 m_byteen", 64'(mb[0]), 64'b0001);
        chk("t2 b1 m_wdata", md[0], 64'h000000AB);
        chk("t2 b1 m_last", 64'(ml[0]), 64'd1);
        wait_idle(0);

        // misaligned sw rejected when splitting is off
        send(1, 32'h3001, 2'b00, 64'h11223344);
        chk("t3 err", 64'(er[1]), 64'd1);
        chk("t3 err_addr", 64'(ea[1]), 64'h3001);
        chk("t3 m_valid", 64'(mv[1]), 64'd0);
        step();
        chk("t3 err drop", 64'(er[1]), 64'd0);
        chk("t3 req_ready", 64'(rr[1]), 64'd1);
        send(1, 32'h3008, 2'b11, 64'h55667788);
        chk("t3 sd32 err", 64'(er[1]), 64'd1);
        chk("t3 sd32 err_addr", 64'(ea[1]), 64'h3008);
        chk("t3 sd32 m_valid", 64'(mv[1]), 64'd0);
        step();
        chk("t3 sd32 req_ready", 64'(rr[1]), 64'd1);
        chk("t3 err_addr hold", 64'(ea[1]), 64'h3008);

        // 64-bit bus: sd then sw in the upper half
        send(2, 32'h40, 2'b11, 64'h0102030405060708);
        chk("t4 sd m_addr", 64'(ma[2]), 64'h40);
        chk("t4 sd m_byteen", 64'(mb[2]), 64'hFF);
        chk("t4 sd m_wdata", md[2], 64'h0102030405060708);
        wait_idle(2);
        send(2, 32'h44, 2'b00, 64'hDEADBEEF);
        chk("t4 sw m_addr", 64'(ma[2]), 64'h40);
        chk("t4 sw m_byteen", 64'(mb[2]), 64'hF0);
        chk("t4 sw m_wdata", md[2], 64'hDEADBEEF00000000);
        wait_idle(2);

        // backpressure on a split beat 0
        mr[0] = 1'b0;
        send(0, 32'h1002, 2'b00, 64'h11223344);
        for (int i = 0; i < 3; i++) begin
            chk("t5 hold m_valid", 64'(mv[0]), 64'd1);
            chk("t5 hold m_addr", 64'(ma[0]), 64'h1000);
            chk("t5 hold m_byteen", 64'(mb[0]), 64'b1100);
            chk("t5 hold m_wdata", md[0], 64'h33440000);
            chk("t5 hold req_ready", 64'(rr[0]), 64'd0);
            step();
        end
        mr[0] = 1'b1;
        step();
        chk("t5 b1 m_addr", 64'(ma[0]), 64'h1004);
        chk("t5 b1 m_byteen", 64'(mb[0]), 64'b0011);
        chk("t5 b1 m_wdata", md[0], 64'h00001122);
        chk("t5 b1 m_last", 64'(ml[0]), 64'd1);
        wait_idle(0);

        // reset during beat 1 abandons the request
        mr[0] = 1'b0;
        send(0, 32'h2006, 2'b00, 64'hCAFEF00D);
        mr[0] = 1'b1;
        step();
        chk("t6 in beat1 m_addr", 64'(ma[0]), 64'h2008);
        mr[0] = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("t6 after reset m_valid", 64'(mv[0]), 64'd0);
        chk("t6 after reset req_ready", 64'(rr[0]), 64'd1);
        mr[0] = 1'b1;
        step();
        chk("t6 no leftover beat", 64'(mv[0]), 64'd0);
        send(0, 32'h2005, 2'b10, 64'h000000AA);
        chk("t6 next m_addr", 64'(ma[0]), 64'h2004);
        chk("t6 next m_byteen", 64'(mb[0]), 64'b0010);
        chk("t6 next m_wdata", md[0], 64'h0000AA00);
        wait_idle(0);

        // sweep of widths and offsets, model-checked every cycle
        for (int k = 0; k < 3; k++) begin
            for (int w = 0; w < 4; w++) begin
                for (int off = 0; off < 8; off++) begin
                    pat = 64'hF1E2D3C4B5A69788 ^ 64'((off << 4) | w);
                    if (off == 5) mr[k] = 1'b0;
                    send(k, 32'h800 + 32'(k * 256) + 32'(w * 16) + 32'(off), 2'(w), pat);
                    if (off == 5) begin
                        step();
                        mr[k] = 1'b1;
                    end
                    wait_idle(k);
                end
            end
        end

        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
